// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, operands
// processed LSB-first one bit per clock behind ready/valid handshakes on both
// sides. Subtraction is a + ~b + 1, so cout=1 means "no borrow".
module serial_add_sub #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum;
  logic             fa_carry;

  // Single full-adder cell working on the current LSBs and the carry flop.
  always_comb begin
    fa_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_carry = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
  end

  // Next-state and datapath update; result registers only move on RUN->DONE.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = fa_carry;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB, fa_carry the carry out of it
          sum_d   = {fa_sum, res_sh_q[WIDTH-1:1]};
          cout_d  = fa_carry;
          ovf_d   = carry_q ^ fa_carry;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake flags decode directly from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: an 8-bit and a 16-bit instance, directed vectors
// with literal expectations, and an arithmetic reference model checked every
// cycle by one compare process.
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid8, in_ready8, sub8, cin8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        in_valid16, in_ready16, sub16, cin16, out_valid16, out_ready16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  serial_add_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_add_sub #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .sub(sub16), .cin(cin16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected result of the operation in flight, and the result that must be held.
  logic [7:0]  exp8_sum  = '0, held8_sum  = '0;
  logic        exp8_cout = 0,  held8_cout = 0, exp8_ovf = 0, held8_ovf = 0;
  logic [15:0] exp16_sum = '0, held16_sum = '0;
  logic        exp16_cout = 0, held16_cout = 0, exp16_ovf = 0, held16_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    total_cnt++;
    $display("FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum[31:0]}.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic c);
    longint full, half, ua, ub, sa, sb, r, sr, ci;
    logic   co, ov;
    full = longint'(1) << w;
    half = full >> 1;
    ua   = longint'(a);
    ub   = longint'(b);
    ci   = c ? 1 : 0;
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    if (s) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + ci;
      co = (r >= full);
      sr = sa + sb + ci;
    end
    ov = (sr >= half) || (sr < -half);
    r  = r & (full - 1);
    return {ov, co, r[31:0]};
  endfunction

  // Single compare process: reset values, completed results, and hold behaviour.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid8", 32'(out_valid8), 32'd0);
      chk("rst_sum8",   32'(sum8),       32'd0);
      chk("rst_cout8",  32'(cout8),      32'd0);
      chk("rst_ovf8",   32'(ovf8),       32'd0);
      chk("rst_ready8", 32'(in_ready8),  32'd1);
      chk("rst_valid16", 32'(out_valid16), 32'd0);
      chk("rst_sum16",   32'(sum16),       32'd0);
      held8_sum = '0;  held8_cout = 0;  held8_ovf = 0;
      held16_sum = '0; held16_cout = 0; held16_ovf = 0;
    end else begin
      if (out_valid8) begin
        chk("res_sum8",  32'(sum8),  32'(exp8_sum));
        chk("res_cout8", 32'(cout8), 32'(exp8_cout));
        chk("res_ovf8",  32'(ovf8),  32'(exp8_ovf));
        chk("res_ready8", 32'(in_ready8), 32'd0);
        held8_sum = exp8_sum; held8_cout = exp8_cout; held8_ovf = exp8_ovf;
      end else begin
        chk("hold_sum8",  32'(sum8),  32'(held8_sum));
        chk("hold_cout8", 32'(cout8), 32'(held8_cout));
        chk("hold_ovf8",  32'(ovf8),  32'(held8_ovf));
      end
      if (out_valid16) begin
        chk("res_sum16",  32'(sum16),  32'(exp16_sum));
        chk("res_cout16", 32'(cout16), 32'(exp16_cout));
        chk("res_ovf16",  32'(ovf16),  32'(exp16_ovf));
        held16_sum = exp16_sum; held16_cout = exp16_cout; held16_ovf = exp16_ovf;
      end else begin
        chk("hold_sum16",  32'(sum16),  32'(held16_sum));
        chk("hold_cout16", 32'(cout16), 32'(held16_cout));
        chk("hold_ovf16",  32'(ovf16),  32'(held16_ovf));
      end
    end
  end

  int acc8_cyc, acc16_cyc;

  task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
    logic [33:0] m;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = s; cin8 = c; in_valid8 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready8) break;
      @(negedge clk);
    end
    if (!in_ready8) timeout("accept8");
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    // Operands must be ignored after the accept edge.
    a8 = ~a; b8 = ~b; sub8 = ~s; cin8 = ~c;
    m = model(8, 32'(a), 32'(b), s, c);
    exp8_sum = m[7:0]; exp8_cout = m[32]; exp8_ovf = m[33];
    acc8_cyc = cyc;
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!out_valid8 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("latency8", 32'(n), 32'd8);
  endtask

  task automatic drain8();
    @(negedge clk); out_ready8 = 1'b1;
    @(negedge clk); out_ready8 = 1'b0;
  endtask

  task automatic accept16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic c);
    logic [33:0] m;
    @(negedge clk);
    a16 = a; b16 = b; sub16 = s; cin16 = c; in_valid16 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (in_ready16) break;
      @(negedge clk);
    end
    if (!in_ready16) timeout("accept16");
    @(posedge clk);
    #1;
    in_valid16 = 1'b0;
    a16 = ~a; b16 = ~b; sub16 = ~s; cin16 = ~c;
    m = model(16, 32'(a), 32'(b), s, c);
    exp16_sum = m[15:0]; exp16_cout = m[32]; exp16_ovf = m[33];
    acc16_cyc = cyc;
  endtask

  task automatic wait_done16();
    int n = 0;
    while (!out_valid16 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("latency16", 32'(n), 32'd16);
  endtask

  typedef struct {
    logic [15:0] a, b;
    logic        s, c;
    logic [15:0] sum;
    logic        co, ov;
  } vec_t;

  // Hand-computed vectors.
  vec_t v8[7] = '{
    '{16'd200,  16'd100,  1'b0, 1'b1, 16'd45,   1'b1, 1'b0},
    '{16'h7F,   16'h01,   1'b0, 1'b0, 16'h80,   1'b0, 1'b1},
    '{16'h80,   16'h01,   1'b1, 1'b0, 16'h7F,   1'b1, 1'b1},
    '{16'd5,    16'd7,    1'b1, 1'b1, 16'hFE,   1'b0, 1'b0},
    '{16'hFF,   16'hFF,   1'b0, 1'b1, 16'hFF,   1'b1, 1'b0},
    '{16'h80,   16'h80,   1'b0, 1'b0, 16'h00,   1'b1, 1'b1},
    '{16'h03,   16'h80,   1'b1, 1'b0, 16'h83,   1'b0, 1'b1}
  };

  vec_t v16[5] = '{
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
    '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1},
    '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1},
    '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0}
  };

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, expected $finish");
    $fatal(1);
  end

  initial begin
    int prev;
    rst_n = 1'b0;
    in_valid8 = 0; a8 = '0; b8 = '0; sub8 = 0; cin8 = 0; out_ready8 = 0;
    in_valid16 = 0; a16 = '0; b16 = '0; sub16 = 0; cin16 = 0; out_ready16 = 0;

    // Reset held three cycles, then released.
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready8", 32'(in_ready8),  32'd1);
    chk("post_rst_valid8", 32'(out_valid8), 32'd0);
    chk("post_rst_sum8",   32'(sum8),       32'd0);

    // Directed 8-bit vectors with literal expectations.
    foreach (v8[i]) begin
      accept8(v8[i].a[7:0], v8[i].b[7:0], v8[i].s, v8[i].c);
      wait_done8();
      chk("lit_sum8",  32'(sum8),  32'(v8[i].sum[7:0]));
      chk("lit_cout8", 32'(cout8), 32'(v8[i].co));
      chk("lit_ovf8",  32'(ovf8),  32'(v8[i].ov));
      drain8();
    end

    // Back-pressure: result held, new operands waiting, nothing accepted.
    accept8(8'd10, 8'd20, 1'b0, 1'b0);
    wait_done8();
    @(negedge clk);
    a8 = 8'd99; b8 = 8'd1; sub8 = 1'b1; cin8 = 1'b0; in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid8", 32'(out_valid8), 32'd1);
      chk("bp_ready8", 32'(in_ready8),  32'd0);
      chk("bp_sum8",   32'(sum8),       32'd30);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid8", 32'(out_valid8), 32'd0);
    chk("bp_release_ready8", 32'(in_ready8),  32'd1);
    out_ready8 = 1'b0;
    accept8(8'd99, 8'd1, 1'b1, 1'b0);
    wait_done8();
    chk("bp_second_sum8", 32'(sum8), 32'd98);
    drain8();

    // Reset in the middle of RUN, then a fresh operation.
    accept8(8'd77, 8'd33, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid8", 32'(out_valid8), 32'd0);
    chk("mid_rst_ready8", 32'(in_ready8),  32'd1);
    chk("mid_rst_sum8",   32'(sum8),       32'd0);
    accept8(8'd1, 8'd1, 1'b0, 1'b0);
    wait_done8();
    chk("mid_rst_res_sum8",  32'(sum8),  32'd2);
    chk("mid_rst_res_cout8", 32'(cout8), 32'd0);
    chk("mid_rst_res_ovf8",  32'(ovf8),  32'd0);
    drain8();

    // 16-bit instance, back-to-back with out_ready held high.
    out_ready16 = 1'b1;
    prev = 0;
    foreach (v16[i]) begin
      accept16(v16[i].a, v16[i].b, v16[i].s, v16[i].c);
      if (i > 0) chk("throughput16", 32'(acc16_cyc - prev), 32'd18);
      prev = acc16_cyc;
      wait_done16();
      chk("lit_sum16",  32'(sum16),  32'(v16[i].sum));
      chk("lit_cout16", 32'(cout16), 32'(v16[i].co));
      chk("lit_ovf16",  32'(ovf16),  32'(v16[i].ov));
    end
    @(negedge clk);
    @(negedge clk);
    out_ready16 = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
